instr_mem_loadable: RTL and testbench
=====================================

// Module: instr_mem_loadable
// PURPOSE
//  Parametrised synchronous instruction memory for the emulated core; successor to the fixed-content ROM.
//  Program image is streamed in over a valid/ready load port, then fetched with a 1-cycle registered read.
//  Adds stall (fetch hold), bounds checking against loaded length, and NOP substitution on bad fetches.
//  Sits between the testbench/program loader and the core's fetch stage.
// PARAMETERS
//  ROM_SIZE     512        number of instruction words
//  INSTR_WIDTH  9          bits per instruction
//  ADDR_WIDTH   $clog2(ROM_SIZE)+1   fetch address width; MSB headroom lets the core present out-of-range PCs
//  NOP_INSTR    '0         word driven on instr_out for any invalid fetch
// PORTS
//  clk          in   1            clock, all state on rising edge
//  reset_n      in   1            asynchronous, active-low reset
//  load_start   in   1            pulse: begin new program load (ignored while loading)
//  load_valid   in   1            load word present
//  load_data    in   INSTR_WIDTH  load word
//  load_last    in   1            qualifies final load word
//  load_ready   out  1            block accepts load word this cycle
//  load_done    out  1            program present, fetch enabled (level)
//  prog_len     out  ADDR_WIDTH   number of words loaded
//  fetch_en     in   1            request read of instr_addr; low = stall, hold outputs
//  instr_addr   in   ADDR_WIDTH   fetch address (PC)
//  instr_out    out  INSTR_WIDTH  registered instruction
//  instr_valid  out  1            instr_out corresponds to a completed fetch
//  addr_err     out  1            1-cycle flag aligned with instr_out: fetch was out of range or before load
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; load_ready=0, load_done=0, prog_len=0,
//   instr_out=NOP_INSTR, instr_valid=0, addr_err=0, write pointer=0. Memory array is NOT cleared.
//  FSM IDLE -> LOAD on load_start; RUN -> LOAD on load_start (reload; load_done drops next cycle).
//  LOAD: load_ready=1. Word accepted when load_valid&load_ready: mem[wp]<=load_data, wp++, prog_len<=wp+1.
//   LOAD -> RUN when accepted word has load_last=1 OR wp==ROM_SIZE-1 (array full; load_last not needed).
//   load_start during LOAD ignored. Words offered outside LOAD are dropped (load_ready=0).
//  RUN: load_done=1. Fetch latency 1 cycle: fetch_en=1 at edge N -> instr_out/instr_valid valid after edge N.
//   In range (instr_addr < prog_len): instr_out=mem[instr_addr], addr_err=0.
//   Out of range (instr_addr >= prog_len, incl. >= ROM_SIZE): instr_out=NOP_INSTR, addr_err=1, instr_valid=1.
//   fetch_en=0: instr_out and instr_valid hold previous value; addr_err cleared.
//  fetch_en=1 in IDLE/LOAD: instr_out=NOP_INSTR, instr_valid=0, addr_err=1.
//  Simultaneous load write and fetch cannot occur (fetch only in RUN); no read-during-write bypass needed.
//  Reset mid-load: return to IDLE, prog_len=0; partially written words remain but are unreachable
//   (prog_len gates all reads) until a new load completes.
//  Widths: wp is $clog2(ROM_SIZE) bits, prog_len ADDR_WIDTH bits (holds ROM_SIZE exactly); no wrap past full.
// STRUCTURE
//  Package instr_mem_pkg: ld_state_t enum {IDLE, LOAD, RUN}; default NOP constant; ADDR_WIDTH function.
//  Sub-module instr_ram_sp: 1 write port + 1 registered read port, no reset on array (maps to BRAM).
//  Top holds FSM, write pointer, prog_len, bounds compare, NOP mux and output/valid registers.
// TESTING
//  Load 33 words (last on word 32), fetch 0..32 -> matching words, instr_valid=1, addr_err=0, prog_len=33.
//  After above, fetch addr 33 and 600 -> instr_out=NOP_INSTR, addr_err=1 each, one cycle after request.
//  fetch_en low 3 cycles mid-stream -> instr_out/instr_valid frozen; resume yields next address's word.
//  Load 512 words without load_last -> RUN after word 511, load_ready=0, word 512 dropped, prog_len=512.
//  Assert reset_n=0 after 10 load words, reload 4 words -> prog_len=4; fetch addr 5 -> addr_err=1.
//  fetch_en=1 before any load -> instr_valid=0, addr_err=1; load_start in RUN -> load_done=0 next cycle.

Source files
------------

// File: rtl/instr_mem_pkg.sv
//------------------------------------------------------------------------------
// instr_mem_pkg
//   Shared types and helpers for the loadable instruction memory.
//   - ld_state_t   : loader/fetch FSM states
//   - DEFAULT_NOP  : default instruction word returned on any invalid fetch
//   - addr_width_f : fetch address width for a given depth; one extra MSB so
//                    the core can present PCs at or beyond the array size
//------------------------------------------------------------------------------
package instr_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } ld_state_t;

   localparam int unsigned DEFAULT_NOP = 0;

   function automatic int addr_width_f(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/instr_ram_sp.sv
//------------------------------------------------------------------------------
// instr_ram_sp
//   Simple dual-ported storage: one write port and one registered read port.
//   The array and the read register have no reset, so this maps onto block RAM.
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     re     in   read enable; when low the read register holds its value
//     raddr  in   read address
//     rdata  out  registered read data (valid the cycle after re)
//------------------------------------------------------------------------------
module instr_ram_sp #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 9
)(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
//------------------------------------------------------------------------------
// instr_mem_loadable
//   Instruction memory for the emulated core. A program image is streamed in
//   over the load port, after which the core fetches with a 1-cycle registered
//   read. Fetches beyond the loaded length (or before any load completes)
//   return NOP_INSTR and raise addr_err for one cycle.
//
//   Load handshake: a word transfers on a rising edge where load_valid and
//   load_ready are both high. load_ready is high only in the LOAD state; the
//   source may hold load_valid high across cycles, and words offered while
//   load_ready is low are simply dropped.
//
//   Ports:
//     clk          in   clock, all state on rising edge
//     reset_n      in   asynchronous active-low reset
//     load_start   in   pulse: begin a new program load (ignored while loading)
//     load_valid   in   load word present
//     load_data    in   load word
//     load_last    in   marks the final word of the image
//     load_ready   out  load word accepted this cycle if load_valid
//     load_done    out  program present, fetch enabled (level)
//     prog_len     out  number of words loaded
//     fetch_en     in   fetch instr_addr; low = stall, outputs hold
//     instr_addr   in   fetch address (PC)
//     instr_out    out  fetched instruction (NOP_INSTR on invalid fetch)
//     instr_valid  out  instr_out belongs to a completed fetch in RUN
//     addr_err     out  1-cycle flag aligned with instr_out: bad fetch
//     dbg_state    out  current FSM state, for observation only
//------------------------------------------------------------------------------
module instr_mem_loadable
   import instr_mem_pkg::*;
#(
   parameter int                     ROM_SIZE    = 512,
   parameter int                     INSTR_WIDTH = 9,
   parameter int                     ADDR_WIDTH  = addr_width_f(ROM_SIZE),
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(DEFAULT_NOP)
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   load_start,
   input  logic                   load_valid,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic                   load_last,
   output logic                   load_ready,
   output logic                   load_done,
   output logic [ADDR_WIDTH-1:0]  prog_len,
   input  logic                   fetch_en,
   input  logic [ADDR_WIDTH-1:0]  instr_addr,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic                   instr_valid,
   output logic                   addr_err,
   output ld_state_t              dbg_state
);

   localparam int WP_W = $clog2(ROM_SIZE);

   ld_state_t              state_q, state_d;
   logic [WP_W-1:0]        wp_q, wp_d;
   logic [ADDR_WIDTH-1:0]  prog_len_q, prog_len_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   // Selects RAM data vs. NOP on the output; the RAM read register itself
   // holds across stalls, so this flag is all that has to be remembered.
   logic                   use_ram_q, use_ram_d;

   logic                   accept;
   logic                   wp_full;
   logic                   in_range;
   logic                   ram_re;
   logic [INSTR_WIDTH-1:0] ram_rdata;

   assign load_ready = (state_q == LOAD);
   assign load_done  = (state_q == RUN);
   assign accept     = load_valid && load_ready;
   assign wp_full    = (wp_q == WP_W'(ROM_SIZE - 1));

   // prog_len gates every read, so stale words from an aborted or shorter
   // earlier load are never visible.
   assign in_range   = (state_q == RUN) && (instr_addr < prog_len_q);
   assign ram_re     = fetch_en && in_range;

   //---------------------------------------------------------------------------
   // FSM, write pointer and program length
   //---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wp_d       = wp_q;
      prog_len_d = prog_len_q;
      case (state_q)
         IDLE, RUN: begin
            if (load_start) begin
               state_d    = LOAD;
               wp_d       = '0;
               prog_len_d = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               // Pointer saturates at the last slot; the FSM leaves LOAD on
               // that same word, so it never wraps.
               if (!wp_full) begin
                  wp_d = wp_q + WP_W'(1);
               end
               prog_len_d = ADDR_WIDTH'(wp_q) + ADDR_WIDTH'(1);
               if (load_last || wp_full) begin
                  state_d = RUN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Fetch response
   //---------------------------------------------------------------------------
   always_comb begin
      valid_d   = valid_q;
      use_ram_d = use_ram_q;
      err_d     = 1'b0;
      if (fetch_en) begin
         if (state_q == RUN) begin
            valid_d   = 1'b1;
            use_ram_d = in_range;
            err_d     = !in_range;
         end else begin
            valid_d   = 1'b0;
            use_ram_d = 1'b0;
            err_d     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wp_q       <= '0;
         prog_len_q <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         use_ram_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wp_q       <= wp_d;
         prog_len_q <= prog_len_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         use_ram_q  <= use_ram_d;
      end
   end

   instr_ram_sp #(
      .DEPTH (ROM_SIZE),
      .WIDTH (INSTR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (wp_q),
      .wdata (load_data),
      .re    (ram_re),
      .raddr (instr_addr[WP_W-1:0]),
      .rdata (ram_rdata)
   );

   assign instr_out   = use_ram_q ? ram_rdata : NOP_INSTR;
   assign instr_valid = valid_q;
   assign addr_err    = err_q;
   assign prog_len    = prog_len_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;
  import instr_mem_pkg::*;

  localparam int ROM_SIZE = 512;
  localparam int IW       = 9;
  localparam int AW       = 10;
  localparam int W        = IW + 2;   // {instr_valid, addr_err, instr_out}
  localparam logic [IW-1:0] NOP = '0;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_start, load_valid, load_last, fetch_en;
  logic [IW-1:0] load_data;
  logic [AW-1:0] instr_addr;
  logic          load_ready, load_done, instr_valid, addr_err;
  logic [AW-1:0] prog_len;
  logic [IW-1:0] instr_out;
  ld_state_t     dbg_state;

  always #5 clk = ~clk;

  instr_mem_loadable dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .prog_len    (prog_len),
    .fetch_en    (fetch_en),
    .instr_addr  (instr_addr),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .addr_err    (addr_err),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int            n_checks = 0;
  int            n_errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  last_exp;
  logic          fetched = 1'b0;

  logic [IW-1:0] model_mem [ROM_SIZE];
  int            model_len = 0;
  int            model_wp  = 0;
  logic          model_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_fetch(input int a);
    if (!model_run) return {1'b0, 1'b1, NOP};
    if (a < model_len) return {1'b1, 1'b0, model_mem[a]};
    return {1'b1, 1'b1, NOP};
  endfunction

  // monitor: note which edges carried a fetch, compare on the following negedge
  always @(posedge clk) fetched = reset_n && fetch_en;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset_n) begin
      last_exp = {1'b0, 1'b0, NOP};
    end else if (fetched) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL fetch_response: DUT output with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("fetch instr_out", instr_out, e[IW-1:0]);
        check("fetch instr_valid", instr_valid, e[W-1]);
        check("fetch addr_err", addr_err, e[W-2]);
        last_exp = e;
      end
    end else begin
      check("hold instr_out", instr_out, last_exp[IW-1:0]);
      check("hold instr_valid", instr_valid, last_exp[W-1]);
      check("idle addr_err", addr_err, 0);
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fetch_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic fetch(input int a);
    fetch_en   = 1'b1;
    instr_addr = AW'(a);
    exp_q.push_back(exp_fetch(a));
    tick();
  endtask

  task automatic start_load();
    fetch_en   = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    model_run  = 1'b0;
    model_wp   = 0;
    model_len  = 0;
  endtask

  task automatic load_word(input logic [IW-1:0] d, input logic last, input logic start_pulse);
    fetch_en   = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    load_start = start_pulse;
    @(negedge clk);
    check("load_ready in LOAD", load_ready, 1);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_start = 1'b0;
    model_mem[model_wp] = d;
    model_wp++;
    model_len = model_wp;
    if (last || model_wp == ROM_SIZE) model_run = 1'b1;
  endtask

  // offer a word while not in LOAD; it must be refused
  task automatic offer_dropped(input logic [IW-1:0] d);
    fetch_en   = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = 1'b1;
    @(negedge clk);
    check("load_ready outside LOAD", load_ready, 0);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic check_loaded(input int len);
    @(negedge clk);
    check("load_done after load", load_done, 1);
    check("load_ready after load", load_ready, 0);
    check("prog_len after load", prog_len, len);
    check("state after load", dbg_state, RUN);
    tick();
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset_n    = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    fetch_en   = 1'b0;
    instr_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset state
    @(negedge clk);
    check("reset load_ready", load_ready, 0);
    check("reset load_done", load_done, 0);
    check("reset prog_len", prog_len, 0);
    check("reset state", dbg_state, IDLE);
    tick();

    // fetch before any load
    fetch(0);
    fetch(7);
    idle(1);
    offer_dropped(9'h1AA);

    // 33-word load, last on word 32
    start_load();
    @(negedge clk);
    check("LOAD load_done", load_done, 0);
    tick();
    for (int i = 0; i < 33; i++) load_word(9'(i * 13 + 5), (i == 32), 1'b0);
    check_loaded(33);

    // fetch 0..32 with a 3-cycle stall, then out of range
    for (int a = 0; a < 16; a++) fetch(a);
    idle(3);
    for (int a = 16; a < 33; a++) fetch(a);
    fetch(33);
    fetch(600);
    fetch(1023);
    idle(2);

    // words offered in RUN are dropped; contents unchanged
    offer_dropped(9'h155);
    fetch(0);
    fetch(32);
    idle(1);

    // reload from RUN: load_done drops next cycle
    start_load();
    @(negedge clk);
    check("reload load_done", load_done, 0);
    check("reload load_ready", load_ready, 1);
    check("reload prog_len", prog_len, 0);
    tick();
    fetch(3);
    idle(1);

    // full 512-word load without load_last
    for (int i = 0; i < ROM_SIZE; i++) load_word(9'(i) ^ 9'h0A5, 1'b0, 1'b0);
    check_loaded(512);
    offer_dropped(9'h000);
    fetch(0);
    fetch(511);
    fetch(300);
    fetch(33);
    fetch(512);
    fetch(1023);
    idle(2);

    // reset in the middle of a load
    start_load();
    for (int i = 0; i < 10; i++) load_word(9'(i + 100), 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    check("mid-load reset prog_len", prog_len, 0);
    check("mid-load reset load_ready", load_ready, 0);
    check("mid-load reset state", dbg_state, IDLE);
    model_run = 1'b0;
    model_len = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    fetch(0);
    idle(1);

    // reload 4 words; a load_start during LOAD must be ignored
    start_load();
    load_word(9'h1F0, 1'b0, 1'b0);
    load_word(9'h1F1, 1'b0, 1'b1);
    load_word(9'h1F2, 1'b0, 1'b0);
    load_word(9'h1F3, 1'b1, 1'b0);
    check_loaded(4);
    for (int a = 0; a < 4; a++) fetch(a);
    fetch(5);
    fetch(9);
    fetch(4);
    idle(3);

    check("exp_q drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
